// File: rtl/char_box_reader_pkg.sv
// Shared definitions for the character segmentation and box readout stages.
// Holds the frame geometry, the frame RAM address width, the box coordinate
// width, the readout FSM state type and the box descriptor struct.
package char_box_reader_pkg;

    localparam int H_RES  = 480;  // frame width in pixels
    localparam int V_RES  = 272;  // frame height in lines
    localparam int AW     = 17;   // frame RAM address width
    localparam int BOX_W  = 9;    // box coordinate width
    localparam int DATA_W = 8;    // pixel width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [BOX_W-1:0] upper;  // first row, inclusive
        logic [BOX_W-1:0] lower;  // last row, exclusive
        logic [BOX_W-1:0] lift;   // first column, inclusive
        logic [BOX_W-1:0] right;  // last column, exclusive
    } box_t;

    // An empty, inverted or off-frame box cannot be read back.
    function automatic logic box_invalid(input box_t b);
        return (b.lower <= b.upper) || (b.right <= b.lift) ||
               (b.lower > BOX_W'(V_RES)) || (b.right > BOX_W'(H_RES));
    endfunction

endpackage

// File: rtl/char_box_reader_skid_buf.sv
// box_skid_buf: 2-entry valid/ready buffer between the frame RAM return path
// and the pixel stream.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write one entry (caller guarantees a free slot)
//   pop_i           consume the head entry (ignored when empty)
//   data_o, valid_o head entry and its valid flag
//   occ_o           current occupancy (0..2), used for read credit
module box_skid_buf #(
    parameter int W = 10
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic         pop;

    assign pop = pop_i && (cnt_q != 2'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (push_i) wr_q <= ~wr_q;
            if (pop)    rd_q <= ~rd_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

    // Storage carries no reset; emptiness is tracked by cnt_q alone.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign valid_o = (cnt_q != 2'd0);
    assign occ_o   = cnt_q;

endmodule

// File: rtl/char_box_reader.sv
// char_box_reader: reads one character box back from the 480x272 binarized
// frame RAM and streams its pixels in raster order with row/box markers.
// Ports:
//   clock, rst_n            clock, asynchronous active-low reset
//   start                   pulse: latch Upper/Lower/Lift/Right_data, begin
//   rd_en, rd_addr, rd_data frame RAM read port (1-cycle read latency)
//   pix_*                   valid/ready pixel stream with eol/eof markers
//   busy, done, err         status; err pulses with done for an invalid box
// Optional build macro BOX_INVERT_EN: pixels are inverted on the way out and
// a 16-bit black_cnt output counts delivered beats whose RAM value != 0xFF.
module char_box_reader
    import char_box_reader_pkg::*;
(
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BOX_W-1:0]  Upper_data,
    input  logic [BOX_W-1:0]  Lower_data,
    input  logic [BOX_W-1:0]  Lift_data,
    input  logic [BOX_W-1:0]  Right_data,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              done,
    output logic              err
`ifdef BOX_INVERT_EN
    ,
    output logic [15:0]       black_cnt
`endif
);

    state_t            state_q, state_d;
    box_t              box_q, box_d;
    logic [BOX_W-1:0]  row_q, row_d;
    logic [BOX_W-1:0]  col_q, col_d;
    logic [AW-1:0]     base_q, base_d;
    logic              err_q, err_d;
    logic              inflight_q;
    logic [1:0]        tag_q;        // {eol, eof} of the read in flight

    logic              issue;
    logic              last_col, last_row;
    logic              pop;
    logic [1:0]        occ;
    logic [2:0]        level;
    logic              credit;
    logic [DATA_W+1:0] push_data;
    logic [DATA_W+1:0] buf_data;
    logic              buf_valid;

    assign last_col = (col_q == box_q.right - BOX_W'(1));
    assign last_row = (row_q == box_q.lower - BOX_W'(1));
    assign pop      = buf_valid && pix_ready;

    // Buffer slots already committed after this cycle's pop; a new read is
    // allowed only if its data will find a free slot when it returns.
    assign level  = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign credit = (level < 3'd2);

    always_comb begin
        state_d = state_q;
        box_d   = box_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        err_d   = err_q;
        issue   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    box_d   = '{upper: Upper_data, lower: Lower_data,
                                lift: Lift_data, right: Right_data};
                    err_d   = 1'b0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (box_invalid(box_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    base_d  = AW'(box_q.upper) * AW'(H_RES);
                    row_d   = box_q.upper;
                    col_d   = box_q.lift;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (credit) begin
                    issue = 1'b1;
                    if (last_col) begin
                        col_d  = box_q.lift;
                        row_d  = row_q + BOX_W'(1);
                        base_d = base_q + AW'(H_RES);
                        if (last_row) state_d = ST_DRAIN;
                    end else begin
                        col_d = col_q + BOX_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the last beat is being taken this cycle,
                // so done follows the final transfer by one cycle.
                if (!inflight_q && (occ == {1'b0, pop})) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            inflight_q <= issue;
        end
    end

    always_ff @(posedge clock) begin
        box_q  <= box_d;
        row_q  <= row_d;
        col_q  <= col_d;
        base_q <= base_d;
        if (issue) tag_q <= {last_col, last_col && last_row};
    end

    assign rd_en   = issue;
    assign rd_addr = issue ? (base_q + AW'(col_q)) : '0;

`ifdef BOX_INVERT_EN
    assign push_data = {~rd_data, tag_q};
`else
    assign push_data = {rd_data, tag_q};
`endif

    box_skid_buf #(
        .W(DATA_W + 2)
    ) u_buf (
        .clk_i  (clock),
        .rst_ni (rst_n),
        .push_i (inflight_q),
        .data_i (push_data),
        .pop_i  (pop),
        .data_o (buf_data),
        .valid_o(buf_valid),
        .occ_o  (occ)
    );

    // Buffer storage is not reset, so the stream fields are masked while empty.
    assign pix_valid = buf_valid;
    assign pix_data  = buf_valid ? buf_data[DATA_W+1:2] : '0;
    assign pix_eol   = buf_valid && buf_data[1];
    assign pix_eof   = buf_valid && buf_data[0];

    assign busy = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_FIN);
    assign err  = (state_q == ST_FIN) && err_q;

`ifdef BOX_INVERT_EN
    logic [15:0] black_cnt_q;

    // Stored pixels are already inverted: a RAM value != 0xFF shows as != 0x00.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            black_cnt_q <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            black_cnt_q <= '0;
        end else if (pop && (buf_data[DATA_W+1:2] != '0)) begin
            black_cnt_q <= black_cnt_q + 16'd1;
        end
    end

    assign black_cnt = black_cnt_q;
`endif

endmodule

// File: doc/char_box_reader.md
Name: char_box_reader

Overview:
- Reads back one character region from the 480x272 8-bit binarized frame RAM after the segmentation stage has written the boundary addresses.
- Takes the latched Upper/Lower/Lift/Right box and generates raster read addresses over it.
- Absorbs the 1-cycle RAM read latency and streams the box pixels, with row and frame markers, over a valid/ready interface to the recognition stage.

Parameters:
- H_RES, 480, frame width in pixels
- V_RES, 272, frame height in lines
- AW, 17, frame RAM address width (H_RES*V_RES = 130560 < 2^17)

Ports:
- clock  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: latch box and begin readout
- Upper_data  in  9  first row of box, inclusive
- Lower_data  in  9  last row of box, exclusive
- Lift_data  in  9  first column of box, inclusive
- Right_data  in  9  last column of box, exclusive
- rd_en  out  1  frame RAM read strobe
- rd_addr  out  AW  frame RAM address = row*H_RES + col
- rd_data  in  8  RAM data, valid exactly 1 cycle after rd_en
- pix_data  out  8  box pixel
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts; a transfer occurs when pix_valid && pix_ready
- pix_eol  out  1  qualifies the last pixel of a box row
- pix_eof  out  1  qualifies the last pixel of the box
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of readout
- err  out  1  one-cycle pulse, coincident with done, for an invalid box

Behaviour:
- Reset: all outputs 0; FSM to IDLE; in-flight read discarded; output buffer emptied.
- Clocking: everything synchronous to clock except the asynchronous reset.

State machine (IDLE -> LOAD -> RUN -> DRAIN -> FIN -> IDLE):
- IDLE: on start, latch the four box inputs and go to LOAD. start is ignored in all other states.
- LOAD (1 cycle):
  - Box is invalid if Lower<=Upper, Right<=Lift, Lower>V_RES or Right>H_RES.
  - Invalid box: go to FIN with err. No reads are issued and no pixels are produced.
  - Valid box: row_base = Upper*H_RES, col = Lift, row = Upper; go to RUN.
- RUN:
  - Issue one read per cycle while credit is available. rd_addr = row_base + col.
  - col increments; when col = Right-1, col wraps to Lift, row increments and row_base += H_RES.
  - After issuing the read at (Lower-1, Right-1), go to DRAIN.
- DRAIN: wait until no read is in flight and the output buffer is empty, then go to FIN.
- FIN: pulse done (and err if the box was invalid) for 1 cycle, deassert busy, return to IDLE.

Flow control:
- 2-entry output buffer.
- Credit for a read this cycle: occupancy + inflight − pop < 2.
- Sustains 1 pixel/clock while pix_ready is held high.
- Holding pix_ready low never loses or duplicates a pixel.

Stream rules:
- Latency from start to first pix_valid: 4 cycles (start, LOAD, RUN issue, RAM return) when pix_ready=1.
- eol/eof are computed at issue time and travel with the data.
- Exactly (Lower−Upper)*(Right−Lift) beats per box. eof coincides with the final eol.
- pix_data/eol/eof stay stable while pix_valid && !pix_ready.

Boundaries:
- 1x1 box: one beat with eol = eof = 1.
- Full frame (0,272,0,480): final rd_addr = 130559; no address overflow.
- Box input changes during busy have no effect.
- rst_n low mid-RUN: immediate return to IDLE; pix_valid=0 on the next edge.

Optional Feature:
- Macro: BOX_INVERT_EN.
- Defined: pix_data = ~rd_data, so text pixels (0x00) arrive as 0xFF for the recognizer's foreground-high convention. Adds a 16-bit black_cnt output counting delivered beats with original value != 0xFF. black_cnt is cleared on start and stable after done.
- Undefined: pix_data = rd_data unchanged; no black_cnt port.

Decomposition:
- Shared package (shared with the segmentation stage): H_RES, V_RES, AW, the box coordinate width (9), the FSM state typedef, and a box struct {upper, lower, lift, right}.
- One natural sub-module, box_skid_buf: the 2-entry valid/ready buffer carrying {data, eol, eof} and reporting occupancy for credit.
- Address/FSM logic stays in the top.

Test Plan:
- Box (10,12,100,103), pix_ready=1 -> rd_addr 4900,4901,4902,5380,5381,5382; 6 beats with eol on beats 3 and 6, eof on beat 6; done 1 cycle after the last beat.
- Same box, pix_ready toggled 1-0-0-1 repeatedly -> identical 6-beat sequence; no drops or duplicates; data stable while stalled.
- Box (5,5,0,10) and box (0,273,0,10) -> no rd_en, no pix_valid; done = err = 1 for one cycle.
- Full frame (0,272,0,480) -> 130560 beats, last rd_addr 130559, 272 eol pulses, one eof.
- rst_n pulsed low after 3 beats of a 20-beat box -> all outputs 0; a fresh start reads the full box from the first pixel.
- start pulsed again during busy, with different box inputs -> ignored; output matches the first box only.
